// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: states, instruction encodings and datapath mux select codes
package mc_ctrl_pkg;
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  typedef enum logic [3:0] {I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD} cls_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] ALUB_RT = 2'd0, ALUB_IMM = 2'd1;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3;
  localparam logic [1:0] MTOR_ALU = 2'd0, MTOR_MEM = 2'd1, MTOR_PC = 2'd2;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: opcode/funct to instruction class, with supported flag
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       ok
);
  assign cls = opcode == OP_RTYPE ? (funct == FN_ADDU ? I_ADDU : funct == FN_SUBU ? I_SUBU :
                                     funct == FN_JR ? I_JR : I_BAD) :
               opcode == OP_ORI ? I_ORI : opcode == OP_LUI ? I_LUI : opcode == OP_LW ? I_LW :
               opcode == OP_SW ? I_SW : opcode == OP_BEQ ? I_BEQ : opcode == OP_J ? I_J :
               opcode == OP_JAL ? I_JAL : I_BAD;
  assign ok = cls != I_BAD;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM; MC_CTRL_PERF_EN adds retired/cycles counters
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  mtor,
  output logic [1:0]  reg_dst,
  output logic        illegal,
`ifdef MC_CTRL_PERF_EN
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic [31:0] cycles
`else
  output logic [2:0]  state
`endif
);
  state_t st, nxt;
  cls_t cls;
  logic ok;
  mc_ctrl_decode u_dec (.opcode(opcode), .funct(funct), .cls(cls), .ok(ok));
  assign state = st;
  // state register
  always_ff @(posedge clk) st <= nxt;
  // next state and control outputs; reset suppresses every enable
  always_comb begin
    nxt = st;
    mem_req = 1'b0;
    mem_we = 1'b0;
    pc_we = 1'b0;
    ir_we = 1'b0;
    reg_we = 1'b0;
    illegal = 1'b0;
    pc_src = PC_PLUS4;
    alu_src = ALUB_RT;
    alu_op = ALU_ADD;
    mtor = MTOR_ALU;
    reg_dst = DST_RT;
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        ir_we = mem_ready;
        pc_we = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        illegal = !ok;
        nxt = ok ? EXEC : FETCH;
      end
      EXEC: begin
        alu_src = cls inside {I_ORI, I_LUI, I_LW, I_SW} ? ALUB_IMM : ALUB_RT;
        alu_op = (cls == I_SUBU || cls == I_BEQ) ? ALU_SUB : cls == I_ORI ? ALU_OR :
                 cls == I_LUI ? ALU_LUI : ALU_ADD;
        pc_src = cls == I_BEQ ? PC_BRANCH : (cls == I_J || cls == I_JAL) ? PC_JUMP :
                 cls == I_JR ? PC_RS : PC_PLUS4;
        pc_we = cls == I_BEQ ? zero : cls inside {I_J, I_JR, I_JAL};
        nxt = cls inside {I_LW, I_SW} ? MEM :
              cls inside {I_ADDU, I_SUBU, I_ORI, I_LUI, I_JAL} ? WB : FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we = cls == I_SW;
        nxt = !mem_ready ? MEM : cls == I_SW ? FETCH : WB;
      end
      WB: begin
        reg_we = 1'b1;
        reg_dst = (cls == I_ADDU || cls == I_SUBU) ? DST_RD : cls == I_JAL ? DST_RA : DST_RT;
        mtor = cls == I_LW ? MTOR_MEM : cls == I_JAL ? MTOR_PC : MTOR_ALU;
        nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
    if (reset) begin
      {mem_req, mem_we, pc_we, ir_we, reg_we, illegal} = '0;
      nxt = FETCH;
    end
  end
`ifdef MC_CTRL_PERF_EN
  // retired counts completed legal instructions; cycles counts non-reset cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (st inside {EXEC, MEM, WB} && nxt == FETCH) retired <= retired + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl against a per-phase instruction model
module tb_mc_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic mem_req, mem_we, pc_we, ir_we, reg_we;
    logic [1:0] pc_src, alu_src;
    logic [2:0] alu_op;
    logic [1:0] mtor, reg_dst;
    logic illegal;
  } obs_t;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic mem_req, mem_we, pc_we, ir_we, reg_we, illegal;
  logic [1:0] pc_src, alu_src, mtor, reg_dst;
  logic [2:0] alu_op, state;
  obs_t obs;
  int errors = 0, checks = 0;
  int mcycles = 0, mretired = 0;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] retired, cycles;
`endif
  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we),
    .ir_we(ir_we), .reg_we(reg_we), .pc_src(pc_src), .alu_src(alu_src),
    .alu_op(alu_op), .mtor(mtor), .reg_dst(reg_dst), .illegal(illegal),
`ifdef MC_CTRL_PERF_EN
    .state(state), .retired(retired), .cycles(cycles)
`else
    .state(state)
`endif
  );
  assign obs = {state, mem_req, mem_we, pc_we, ir_we, reg_we, pc_src, alu_src, alu_op, mtor, reg_dst, illegal};
  always #5 clk = ~clk;

  function automatic obs_t idle(input logic [2:0] s);
    obs_t o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00 && fn inside {6'h21, 6'h23, 6'h08}) ||
           op inside {6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
  endfunction

  function automatic obs_t exp_exec(input logic [5:0] op, input logic [5:0] fn, input logic z);
    obs_t o = idle(3'd2);
    logic jr = op == 6'h00 && fn == 6'h08;
    o.alu_src = {1'b0, op inside {6'h0d, 6'h0f, 6'h23, 6'h2b}};
    o.alu_op = (op == 6'h04 || (op == 6'h00 && fn == 6'h23)) ? 3'd1 : op == 6'h0d ? 3'd2 :
               op == 6'h0f ? 3'd3 : 3'd0;
    o.pc_src = op == 6'h04 ? 2'd1 : op inside {6'h02, 6'h03} ? 2'd2 : jr ? 2'd3 : 2'd0;
    o.pc_we = op == 6'h04 ? z : (op inside {6'h02, 6'h03} || jr);
    return o;
  endfunction

  task automatic chk(input obs_t e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    assert (cycles === 32'(mcycles) && retired === 32'(mretired)) else begin
      errors++;
      $error("FAIL %s_perf: observed cycles=%0d retired=%0d expected cycles=%0d retired=%0d",
             tag, cycles, retired, mcycles, mretired);
    end
`endif
  endtask

  task automatic cyc(input logic rdy, input logic zr, input obs_t e, input string tag);
    mem_ready = rdy;
    zero = zr;
    #1 chk(e, tag);
    @(negedge clk);
    mcycles++;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      #1;
      if (i > 0) chk(idle(3'd0), "reset");
      @(negedge clk);
      mcycles = 0;
      mretired = 0;
    end
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int wf, input int wm);
    obs_t e;
    logic rtype = op == 6'h00 && fn inside {6'h21, 6'h23};
    opcode = op;
    funct = fn;
    e = idle(3'd0);
    e.mem_req = 1'b1;
    for (int i = 0; i < wf; i++) cyc(1'b0, 1'($urandom), e, "fetch_wait");
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    cyc(1'b1, 1'($urandom), e, "fetch");
    e = idle(3'd1);
    e.illegal = !is_legal(op, fn);
    cyc(1'($urandom), 1'($urandom), e, "decode");
    if (e.illegal) return;
    cyc(1'($urandom), z, exp_exec(op, fn, z), "exec");
    if (op inside {6'h23, 6'h2b}) begin
      e = idle(3'd3);
      e.mem_req = 1'b1;
      e.mem_we = op == 6'h2b;
      for (int i = 0; i < wm; i++) cyc(1'b0, 1'($urandom), e, "mem_wait");
      cyc(1'b1, 1'($urandom), e, "mem");
    end
    if (rtype || op inside {6'h0d, 6'h0f, 6'h23, 6'h03}) begin
      e = idle(3'd4);
      e.reg_we = 1'b1;
      e.reg_dst = rtype ? 2'd1 : op == 6'h03 ? 2'd2 : 2'd0;
      e.mtor = op == 6'h23 ? 2'd1 : op == 6'h03 ? 2'd2 : 2'd0;
      cyc(1'($urandom), 1'($urandom), e, "wb");
    end
    mretired++;
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] fns [10];
    obs_t e;
    int k;
    ops = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    fns = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    apply_reset(2);
    run_instr(6'h00, 6'h21, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 3, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h08, 1'b0, 1, 0);
    opcode = 6'h2b;
    funct = 6'h00;
    e = idle(3'd0);
    e.mem_req = 1'b1;
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    cyc(1'b1, 1'b0, e, "sw_fetch");
    cyc(1'b0, 1'b0, idle(3'd1), "sw_decode");
    cyc(1'b0, 1'b0, exp_exec(6'h2b, 6'h00, 1'b0), "sw_exec");
    e = idle(3'd3);
    e.mem_req = 1'b1;
    e.mem_we = 1'b1;
    cyc(1'b0, 1'b0, e, "sw_mem_wait");
    reset = 1'b1;
    mem_ready = 1'b0;
    #1 chk(idle(3'd3), "rst_in_mem");
    @(negedge clk);
    mcycles = 0;
    mretired = 0;
    #1 chk(idle(3'd0), "rst_next");
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 11));
      if (k < 10) run_instr(ops[k], fns[k], 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else run_instr(6'($urandom), 6'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 0);
    end
    e = idle(3'd0);
    e.mem_req = 1'b1;
    cyc(1'b0, 1'b0, e, "final_fetch");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives the select lines of the PC, ALU-B, write-back and register-destination multiplexers, plus all architectural write enables. It also handshakes with a variable-latency memory port. It sits between the instruction register (opcode/funct) and the datapath, replacing combinational single-cycle control.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from the cycle after the IR write
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  store qualifier for mem_req
- pc_we  out  1  PC register load
- ir_we  out  1  instruction register load
- reg_we  out  1  register file write
- pc_src  out  2  0=pc+4, 1=branch target, 2=jump target, 3=rs (jr)
- alu_src  out  2  0=rt, 1=immediate
- alu_op  out  3  0=add, 1=sub, 2=or, 3=lui
- mtor  out  2  write-back data: 0=ALU, 1=memory, 2=PC (link)
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- illegal  out  1  one-cycle pulse on unsupported instruction
- state  out  3  current FSM state (debug)

## Operation
- Supported instructions: addu (00/21), subu (00/23), jr (00/08), ori (0d), lui (0f), lw (23), sw (2b), beq (04), j (02), jal (03). The values are hex opcode/funct.
- FETCH: assert mem_req with mem_we=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - Without mem_ready: stay in FETCH with no enables.
- DECODE: no enables asserted.
  - Supported instruction: go to EXEC.
  - Unsupported instruction: pulse illegal and return to FETCH, so it executes as a nop.
- EXEC: alu_src, alu_op and pc_src are set for the instruction class.
  - R-type, ori, lui: go to WB.
  - lw, sw: go to MEM with alu_op=add, alu_src=1.
  - beq: alu_op=sub, alu_src=0. pc_we=zero with pc_src=1. Go to FETCH.
  - j: pc_we=1, pc_src=2, go to FETCH.
  - jr: pc_we=1, pc_src=3, go to FETCH.
  - jal: pc_we=1, pc_src=2, go to WB.
- MEM: mem_req=1, with mem_we=1 for sw.
  - On mem_ready: lw goes to WB; sw goes to FETCH.
  - Otherwise stay in MEM.
- WB: reg_we=1 for one cycle, then go to FETCH.
  - R-type: reg_dst=1, mtor=0.
  - ori, lui: reg_dst=0, mtor=0.
  - lw: reg_dst=0, mtor=1.
  - jal: reg_dst=2, mtor=2.
- Outputs are Moore/Mealy combinational from the registered state, opcode, funct, zero and mem_ready. Select lines not listed for a state are 0.

## Timing
- Reset:
  - During a reset-high cycle, the next state is FETCH.
  - All enables, mem_req, mem_we and illegal are forced to 0 in that cycle, regardless of state.
  - Reset mid-instruction abandons it with no partial register or PC write.
- Cycle counts with zero-wait memory:
  - R/ori/lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jr: 3.
  - jal: 4.
  - Unsupported instruction: 2.
  - Each memory wait cycle adds 1.
- mem_req stays high through wait cycles. The address and mem_we must not change while mem_req is high.
- pc_we, ir_we and reg_we are never high for more than one cycle per instruction phase.
- jal links the PC value already incremented in FETCH, i.e. pc+4.

## Configuration
- MC_CTRL_PERF_EN defined:
  - Adds output retired (32-bit) and output cycles (32-bit).
  - retired increments on every transition into FETCH from EXEC, MEM or WB. Illegal instructions are not counted.
  - cycles increments every non-reset cycle.
  - Both clear on reset and wrap modulo 2^32.
- MC_CTRL_PERF_EN undefined: neither port nor the counters exist.

## Structure
- Package mc_ctrl_pkg holds:
  - The state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
  - The opcode and funct constants.
  - The pc_src, alu_src, mtor, reg_dst and alu_op encodings. These are shared with the datapath muxes.
- Sub-module mc_ctrl_decode: combinational opcode/funct to instruction-class decode, with a supported flag.
- The FSM and output logic live in mc_ctrl.

## Test plan
- Reset held 2 cycles, then addu with mem_ready=1: state goes 0→1→2→4→0. In WB: reg_we=1, reg_dst=1, mtor=0.
- lw with mem_ready low for 3 cycles in both FETCH and MEM:
  - mem_req stays high throughout.
  - 11 cycles total.
  - In WB: mtor=1, reg_dst=0.
- beq with zero=1, then again with zero=0: in EXEC, pc_we=1 with pc_src=1 for the first, and pc_we=0 for the second. Each takes 3 cycles.
- jal: EXEC has pc_we=1, pc_src=2. WB has reg_we=1, reg_dst=2, mtor=2.
- opcode 6'h3f: illegal pulses for exactly 1 cycle in DECODE. No enables are asserted and the FSM returns to FETCH.
- Reset asserted during a sw in MEM with mem_ready=0:
  - Next cycle mem_req=0, mem_we=0, state=FETCH.
  - With MC_CTRL_PERF_EN defined, retired=0 and cycles=0.
